// File: rtl/x86_encode_if.sv
// Request/byte-stream/result bundle between an instruction source and the x86 encoder.
// The encoder attaches through the slave modport; the driving side uses master.
interface x86_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_opsize16;
    logic        in_addrsize16;
    logic [1:0]  in_rep;
    logic        in_2byte;
    logic [7:0]  in_opcode;
    logic        in_has_modrm;
    logic [7:0]  in_modrm;
    logic        in_has_sib;
    logic [7:0]  in_sib;
    logic [2:0]  in_disp_len;
    logic [31:0] in_disp;
    logic [2:0]  in_imm_len;
    logic [31:0] in_imm;
    logic        out_byte_valid;
    logic        out_byte_ready;
    logic [7:0]  out_byte;
    logic        out_byte_last;
    logic        instr_valid;
    logic [95:0] raw_instr;
    logic [3:0]  instr_len;
    logic        err;

    modport slave (
        input  in_valid, in_opsize16, in_addrsize16, in_rep, in_2byte, in_opcode,
               in_has_modrm, in_modrm, in_has_sib, in_sib, in_disp_len, in_disp,
               in_imm_len, in_imm, out_byte_ready,
        output in_ready, out_byte_valid, out_byte, out_byte_last,
               instr_valid, raw_instr, instr_len, err
    );

    modport master (
        output in_valid, in_opsize16, in_addrsize16, in_rep, in_2byte, in_opcode,
               in_has_modrm, in_modrm, in_has_sib, in_sib, in_disp_len, in_disp,
               in_imm_len, in_imm, out_byte_ready,
        input  in_ready, out_byte_valid, out_byte, out_byte_last,
               instr_valid, raw_instr, instr_len, err
    );
endinterface

// File: rtl/x86_encode.sv
// Sequential x86 instruction encoder: packs one instruction description into IA-32
// byte order, streams it one byte per handshake, then publishes the decoder-format window.
module x86_encode (
    input  logic          clk,
    input  logic          rst,
    x86_encode_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [95:0] buf_r, buf_s;
    logic [3:0]  len_r, len_s;
    logic [3:0]  idx_r, idx_s;
    logic        ob_valid_r, ob_valid_s;
    logic [7:0]  ob_r, ob_s;
    logic        ob_last_r, ob_last_s;
    logic        iv_r, iv_s;
    logic        err_r, err_s;
    logic [95:0] raw_r, raw_s;
    logic [3:0]  ilen_r, ilen_s;

    logic [4:0]  n_s;
    logic        illegal_s;
    logic [95:0] packed_s;
    logic [3:0]  idx_inc_s;
    logic [95:0] shifted_s;

    function automatic logic len_legal(input logic [2:0] l);
        case (l)
            3'd0, 3'd1, 3'd2, 3'd4: len_legal = 1'b1;
            default:                len_legal = 1'b0;
        endcase
    endfunction

    // Lays enabled fields back-to-back from byte 0; only the first 12 survive, which
    // is harmless because anything longer is rejected before it is latched.
    function automatic logic [95:0] pack_bytes(
        input logic        opsize16,
        input logic        addrsize16,
        input logic [1:0]  rep,
        input logic        esc,
        input logic [7:0]  opcode,
        input logic        has_modrm,
        input logic [7:0]  modrm,
        input logic        has_sib,
        input logic [7:0]  sib,
        input logic [2:0]  disp_len,
        input logic [31:0] disp,
        input logic [2:0]  imm_len,
        input logic [31:0] imm
    );
        logic [7:0]  b [0:31];
        logic [4:0]  p;
        logic [95:0] r;
        for (int i = 0; i < 32; i++) b[i] = 8'h00;
        p = 5'd0;
        r = 96'h0;
        if (opsize16)   begin b[p] = 8'h66; p = p + 5'd1; end
        if (addrsize16) begin b[p] = 8'h67; p = p + 5'd1; end
        case (rep)
            2'b01:   begin b[p] = 8'hF3; p = p + 5'd1; end
            2'b10:   begin b[p] = 8'hF2; p = p + 5'd1; end
            default: p = p;
        endcase
        if (esc) begin b[p] = 8'h0F; p = p + 5'd1; end
        b[p] = opcode;
        p = p + 5'd1;
        if (has_modrm) begin b[p] = modrm; p = p + 5'd1; end
        if (has_sib)   begin b[p] = sib;   p = p + 5'd1; end
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < disp_len) begin b[p] = disp[8*k +: 8]; p = p + 5'd1; end
        end
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < imm_len) begin b[p] = imm[8*k +: 8]; p = p + 5'd1; end
        end
        for (int i = 0; i < 12; i++) r[95-8*i -: 8] = b[i];
        return r;
    endfunction

    assign bus.in_ready       = (state_r == IDLE) && !rst;
    assign bus.out_byte_valid = ob_valid_r;
    assign bus.out_byte       = ob_r;
    assign bus.out_byte_last  = ob_last_r;
    assign bus.instr_valid    = iv_r;
    assign bus.raw_instr      = raw_r;
    assign bus.instr_len      = ilen_r;
    assign bus.err            = err_r;

    // Request length and legality, evaluated on the live request fields
    always_comb begin
        n_s = {4'd0, bus.in_opsize16} + {4'd0, bus.in_addrsize16} + {4'd0, (bus.in_rep != 2'b00)}
            + {4'd0, bus.in_2byte} + 5'd1 + {4'd0, bus.in_has_modrm} + {4'd0, bus.in_has_sib}
            + {2'd0, bus.in_disp_len} + {2'd0, bus.in_imm_len};
        illegal_s = (bus.in_rep == 2'b11) || !len_legal(bus.in_disp_len)
                 || !len_legal(bus.in_imm_len) || (bus.in_has_sib && !bus.in_has_modrm)
                 || (n_s > 5'd12);
        packed_s = pack_bytes(bus.in_opsize16, bus.in_addrsize16, bus.in_rep, bus.in_2byte,
                              bus.in_opcode, bus.in_has_modrm, bus.in_modrm, bus.in_has_sib,
                              bus.in_sib, bus.in_disp_len, bus.in_disp, bus.in_imm_len,
                              bus.in_imm);
        idx_inc_s = idx_r + 4'd1;
        shifted_s = buf_r << {idx_inc_s, 3'b000};
    end

    // Next-state and next-output decode for the IDLE/EMIT controller
    always_comb begin
        state_s    = state_r;
        buf_s      = buf_r;
        len_s      = len_r;
        idx_s      = idx_r;
        ob_valid_s = ob_valid_r;
        ob_s       = ob_r;
        ob_last_s  = ob_last_r;
        iv_s       = 1'b0;
        err_s      = 1'b0;
        raw_s      = raw_r;
        ilen_s     = ilen_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    if (illegal_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s    = EMIT;
                        buf_s      = packed_s;
                        len_s      = n_s[3:0];
                        idx_s      = 4'd0;
                        ob_valid_s = 1'b1;
                        ob_s       = packed_s[95:88];
                        ob_last_s  = (n_s == 5'd1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                if (bus.out_byte_ready) begin
                    if (ob_last_r) begin
                        state_s    = IDLE;
                        idx_s      = 4'd0;
                        ob_valid_s = 1'b0;
                        ob_s       = 8'h00;
                        ob_last_s  = 1'b0;
                        raw_s      = buf_r;
                        ilen_s     = len_r;
                        iv_s       = 1'b1;
                    end else begin
                        idx_s     = idx_inc_s;
                        ob_s      = shifted_s[95:88];
                        ob_last_s = (idx_inc_s == (len_r - 4'd1));
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s    = IDLE;
                ob_valid_s = 1'b0;
                ob_last_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset also clears the published window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            buf_r      <= 96'h0;
            len_r      <= 4'd0;
            idx_r      <= 4'd0;
            ob_valid_r <= 1'b0;
            ob_r       <= 8'h00;
            ob_last_r  <= 1'b0;
            iv_r       <= 1'b0;
            err_r      <= 1'b0;
            raw_r      <= 96'h0;
            ilen_r     <= 4'd0;
        end else begin
            state_r    <= state_s;
            buf_r      <= buf_s;
            len_r      <= len_s;
            idx_r      <= idx_s;
            ob_valid_r <= ob_valid_s;
            ob_r       <= ob_s;
            ob_last_r  <= ob_last_s;
            iv_r       <= iv_s;
            err_r      <= err_s;
            raw_r      <= raw_s;
            ilen_r     <= ilen_s;
        end
    end
endmodule

// File: tb/tb_x86_encode.sv
// Self-checking bench for x86_encode: directed vector table, backpressure and reset
// sequences, then randomized requests checked against a queue-based encoding model.
module tb_x86_encode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0]  prev_len = 4'd0;
    logic [95:0] prev_raw = 96'h0;

    x86_encode_if bus ();
    x86_encode dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        opsize16;
        logic        addrsize16;
        logic [1:0]  rep;
        logic        two_byte;
        logic [7:0]  opcode;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [2:0]  disp_len;
        logic [31:0] disp;
        logic [2:0]  imm_len;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        req_t        r;
        logic        exp_err;
        logic [3:0]  exp_len;
        logic [95:0] exp_raw;
    } vec_t;

    function automatic req_t mk(input logic o, input logic a, input logic [1:0] rep,
                                input logic two, input logic [7:0] op, input logic hm,
                                input logic [7:0] m, input logic hs, input logic [7:0] s,
                                input logic [2:0] dl, input logic [31:0] d,
                                input logic [2:0] il, input logic [31:0] im);
        req_t r;
        r.opsize16 = o;   r.addrsize16 = a; r.rep = rep;      r.two_byte = two;
        r.opcode = op;    r.has_modrm = hm; r.modrm = m;      r.has_sib = hs;
        r.sib = s;        r.disp_len = dl;  r.disp = d;       r.imm_len = il;
        r.imm = im;
        return r;
    endfunction

    // Reference encoder: builds the byte list in IA-32 order and judges legality
    function automatic void model(input req_t r, output logic e, output logic [3:0] n,
                                  output logic [95:0] raw);
        logic [7:0]  q[$];
        logic [95:0] w;
        if (r.opsize16)   q.push_back(8'h66);
        if (r.addrsize16) q.push_back(8'h67);
        if (r.rep == 2'b01) q.push_back(8'hF3);
        if (r.rep == 2'b10) q.push_back(8'hF2);
        if (r.two_byte)   q.push_back(8'h0F);
        q.push_back(r.opcode);
        if (r.has_modrm)  q.push_back(r.modrm);
        if (r.has_sib)    q.push_back(r.sib);
        for (int k = 0; k < int'(r.disp_len); k++) q.push_back(8'((r.disp >> (8*k)) & 32'hFF));
        for (int k = 0; k < int'(r.imm_len); k++)  q.push_back(8'((r.imm >> (8*k)) & 32'hFF));
        e = (r.rep == 2'b11) || !(r.disp_len inside {3'd0, 3'd1, 3'd2, 3'd4})
         || !(r.imm_len inside {3'd0, 3'd1, 3'd2, 3'd4})
         || (r.has_sib && !r.has_modrm) || (q.size() > 12);
        n = e ? 4'd0 : 4'(q.size());
        raw = 96'h0;
        for (int i = 0; i < q.size() && i < 12; i++) begin
            w = {q[i], 88'h0};
            raw = raw | (w >> (8*i));
        end
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input req_t r);
        bus.in_opsize16   = r.opsize16;   bus.in_addrsize16 = r.addrsize16;
        bus.in_rep        = r.rep;        bus.in_2byte      = r.two_byte;
        bus.in_opcode     = r.opcode;     bus.in_has_modrm  = r.has_modrm;
        bus.in_modrm      = r.modrm;      bus.in_has_sib    = r.has_sib;
        bus.in_sib        = r.sib;        bus.in_disp_len   = r.disp_len;
        bus.in_disp       = r.disp;       bus.in_imm_len    = r.imm_len;
        bus.in_imm        = r.imm;
    endtask

    // One request end to end; abort_after>=0 asserts reset after that many handshakes
    task automatic do_req(input req_t r, input logic exp_err, input logic [3:0] exp_len,
                          input logic [95:0] exp_raw, input int stall_idx, input int stall_n,
                          input logic rand_bp, input int abort_after);
        logic [7:0]  got[$];
        logic [95:0] sh;
        int          stalls;
        int          pulses;
        logic        done;
        logic        rdy;
        stalls = 0; pulses = 0; done = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", 96'(bus.in_ready), 96'd1);
        drive(r);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (exp_err) begin
            chk("err_pulse", 96'(bus.err), 96'd1);
            chk("err_no_byte", 96'(bus.out_byte_valid), 96'd0);
            @(negedge clk);
            chk("err_once", 96'(bus.err), 96'd0);
            chk("err_no_byte2", 96'(bus.out_byte_valid), 96'd0);
            chk("err_no_iv", 96'(bus.instr_valid), 96'd0);
            chk("err_len_kept", 96'(bus.instr_len), 96'(prev_len));
            chk("err_raw_kept", bus.raw_instr, prev_raw);
            return;
        end
        chk("no_err", 96'(bus.err), 96'd0);
        for (int c = 0; c < 64 && !done; c++) begin
            if (abort_after >= 0 && got.size() == abort_after) begin
                rst = 1'b1;
                #1;
                chk("rst_byte_valid", 96'(bus.out_byte_valid), 96'd0);
                chk("rst_byte", 96'(bus.out_byte), 96'd0);
                chk("rst_last", 96'(bus.out_byte_last), 96'd0);
                chk("rst_raw", bus.raw_instr, 96'd0);
                chk("rst_len", 96'(bus.instr_len), 96'd0);
                chk("rst_in_ready", 96'(bus.in_ready), 96'd0);
                chk("rst_iv", 96'(bus.instr_valid), 96'd0);
                prev_len = 4'd0;
                prev_raw = 96'h0;
                bus.out_byte_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (bus.instr_valid) pulses++;
            sh = exp_raw << (8 * got.size());
            chk("byte_valid", 96'(bus.out_byte_valid), 96'd1);
            chk("byte_last", 96'(bus.out_byte_last), 96'(got.size() == int'(exp_len) - 1));
            chk("byte_value", 96'(bus.out_byte), 96'(sh[95:88]));
            rdy = 1'b1;
            if (got.size() == stall_idx && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end else if (rand_bp && $urandom_range(0, 3) == 0) begin
                rdy = 1'b0;
            end
            bus.out_byte_ready = rdy;
            if (rdy) begin
                got.push_back(bus.out_byte);
                if (bus.out_byte_last) done = 1'b1;
            end
            @(negedge clk);
        end
        bus.out_byte_ready = 1'b1;
        chk("completed", 96'(done), 96'd1);
        chk("handshakes", 96'(got.size()), 96'(exp_len));
        chk("iv_during", 96'(pulses), 96'd0);
        chk("iv_pulse", 96'(bus.instr_valid), 96'd1);
        chk("iv_in_ready", 96'(bus.in_ready), 96'd1);
        chk("iv_byte_idle", 96'(bus.out_byte_valid), 96'd0);
        chk("raw_instr", bus.raw_instr, exp_raw);
        chk("instr_len", 96'(bus.instr_len), 96'(exp_len));
        prev_len = exp_len;
        prev_raw = exp_raw;
        @(negedge clk);
        chk("iv_once", 96'(bus.instr_valid), 96'd0);
    endtask

    vec_t        tbl[11];
    req_t        rr;
    logic        m_err;
    logic [3:0]  m_len;
    logic [95:0] m_raw;
    logic [2:0]  lens[4];

    initial begin
        tbl[0]  = '{mk(1'b0,1'b0,2'b00,1'b0,8'h90,1'b0,8'h00,1'b0,8'h00,3'd0,32'h0,3'd0,32'h0),
                    1'b0, 4'd1, 96'h90000000_00000000_00000000};
        tbl[1]  = '{mk(1'b1,1'b0,2'b00,1'b1,8'hAF,1'b1,8'hC3,1'b0,8'h00,3'd0,32'h0,3'd0,32'h0),
                    1'b0, 4'd4, 96'h660FAFC3_00000000_00000000};
        tbl[2]  = '{mk(1'b0,1'b0,2'b00,1'b0,8'hC7,1'b1,8'h84,1'b1,8'h8B,3'd4,32'h12345678,3'd4,32'hDEADBEEF),
                    1'b0, 4'd11, 96'hC7848B78_563412EF_BEADDE00};
        tbl[3]  = '{mk(1'b1,1'b1,2'b01,1'b1,8'hC7,1'b1,8'h84,1'b1,8'h8B,3'd4,32'h12345678,3'd4,32'hDEADBEEF),
                    1'b1, 4'd0, 96'h0};
        tbl[4]  = '{mk(1'b0,1'b0,2'b00,1'b0,8'h8B,1'b1,8'h45,1'b0,8'h00,3'd3,32'h10,3'd0,32'h0),
                    1'b1, 4'd0, 96'h0};
        tbl[5]  = '{mk(1'b0,1'b0,2'b00,1'b0,8'h8B,1'b0,8'h00,1'b1,8'h24,3'd0,32'h0,3'd0,32'h0),
                    1'b1, 4'd0, 96'h0};
        tbl[6]  = '{mk(1'b0,1'b0,2'b11,1'b0,8'hA4,1'b0,8'h00,1'b0,8'h00,3'd0,32'h0,3'd0,32'h0),
                    1'b1, 4'd0, 96'h0};
        tbl[7]  = '{mk(1'b0,1'b0,2'b01,1'b0,8'hA4,1'b0,8'h00,1'b0,8'h00,3'd0,32'h0,3'd0,32'h0),
                    1'b0, 4'd2, 96'hF3A40000_00000000_00000000};
        tbl[8]  = '{mk(1'b0,1'b1,2'b10,1'b1,8'h10,1'b1,8'h05,1'b0,8'h00,3'd2,32'h1234,3'd1,32'h7F),
                    1'b0, 4'd8, 96'h67F20F10_0534127F_00000000};
        tbl[9]  = '{mk(1'b1,1'b1,2'b01,1'b1,8'h80,1'b1,8'h84,1'b1,8'h24,3'd4,32'h11223344,3'd1,32'h55),
                    1'b0, 4'd12, 96'h6667F30F_80842444_33221155};
        tbl[10] = '{mk(1'b1,1'b1,2'b01,1'b1,8'h80,1'b1,8'h84,1'b1,8'h24,3'd4,32'h11223344,3'd2,32'h55),
                    1'b1, 4'd0, 96'h0};

        bus.in_valid = 1'b0;
        bus.out_byte_ready = 1'b1;
        drive(tbl[0].r);
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 96'(bus.in_ready), 96'd0);
        chk("reset_byte_valid", 96'(bus.out_byte_valid), 96'd0);
        chk("reset_byte", 96'(bus.out_byte), 96'd0);
        chk("reset_last", 96'(bus.out_byte_last), 96'd0);
        chk("reset_iv", 96'(bus.instr_valid), 96'd0);
        chk("reset_err", 96'(bus.err), 96'd0);
        chk("reset_raw", bus.raw_instr, 96'd0);
        chk("reset_len", 96'(bus.instr_len), 96'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_req(tbl[i].r, tbl[i].exp_err, tbl[i].exp_len, tbl[i].exp_raw, -1, 0, 1'b0, -1);

        // MOV with the sink stalled for 3 cycles while byte 3 (0x78) is presented
        do_req(tbl[2].r, 1'b0, tbl[2].exp_len, tbl[2].exp_raw, 3, 3, 1'b0, -1);

        // Reset after two bytes of MOV, then a NOP must encode cleanly
        do_req(tbl[2].r, 1'b0, tbl[2].exp_len, tbl[2].exp_raw, -1, 0, 1'b0, 2);
        do_req(tbl[0].r, 1'b0, tbl[0].exp_len, tbl[0].exp_raw, -1, 0, 1'b0, -1);

        lens[0] = 3'd0; lens[1] = 3'd1; lens[2] = 3'd2; lens[3] = 3'd4;
        for (int it = 0; it < 150; it++) begin
            int v;
            rr.opsize16   = 1'($urandom_range(0, 1));
            rr.addrsize16 = 1'($urandom_range(0, 1));
            rr.rep        = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rr.two_byte   = 1'($urandom_range(0, 1));
            rr.opcode     = 8'($urandom);
            rr.has_modrm  = 1'($urandom_range(0, 1));
            rr.modrm      = 8'($urandom);
            rr.has_sib    = ($urandom_range(0, 7) == 0) ? 1'b1 : (rr.has_modrm & 1'($urandom_range(0, 1)));
            rr.sib        = 8'($urandom);
            v = $urandom_range(0, 15);
            rr.disp_len   = (v < 12) ? lens[v % 4] : 3'(v - 9);
            rr.disp       = $urandom;
            v = $urandom_range(0, 15);
            rr.imm_len    = (v < 12) ? lens[v % 4] : 3'(v - 9);
            rr.imm        = $urandom;
            model(rr, m_err, m_len, m_raw);
            do_req(rr, m_err, m_len, m_raw, -1, 0, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/x86_encode.md
# x86_encode

Sequential x86 instruction encoder, the inverse of the instruction decode path. It accepts one structured instruction description per handshake: prefix flags, opcode, ModR/M, SIB, displacement and immediate. It serializes the instruction into legal IA-32 byte order, one byte per cycle on a valid/ready stream. On completion it presents the packed 96-bit `raw_instr` window and `instr_len` in exactly the format the decoder consumes, so the encoder drives decoder and witness-generation benches.

## Interface
- No parameters.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_opsize16  in  1  emit 0x66 prefix
- in_addrsize16  in  1  emit 0x67 prefix
- in_rep  in  2  00 none, 01 0xF3, 10 0xF2, 11 illegal
- in_2byte  in  1  emit 0x0F escape before opcode
- in_opcode  in  8  opcode byte
- in_has_modrm  in  1  emit in_modrm
- in_modrm  in  8  ModR/M byte
- in_has_sib  in  1  emit in_sib; illegal unless in_has_modrm
- in_sib  in  8  SIB byte
- in_disp_len  in  3  displacement bytes: 0, 1, 2 or 4; other values illegal
- in_disp  in  32  displacement, emitted little-endian from bit 0
- in_imm_len  in  3  immediate bytes: 0, 1, 2 or 4; other values illegal
- in_imm  in  32  immediate, emitted little-endian from bit 0
- out_byte_valid  out  1  out_byte valid
- out_byte_ready  in  1  sink accepts byte
- out_byte  out  8  current byte
- out_byte_last  out  1  current byte is the final byte of the instruction
- instr_valid  out  1  one-cycle pulse: raw_instr and instr_len updated
- raw_instr  out  96  byte k at bits [95-8k : 88-8k]; unused bytes zero
- instr_len  out  4  byte count of last completed instruction (1..12)
- err  out  1  one-cycle pulse: request rejected

## Operation
- Byte order: 0x66, 0x67, rep byte, 0x0F, opcode, ModR/M, SIB, disp LSB first, imm LSB first. Each element is emitted only if enabled.
- N = prefixes + escape + 1 + modrm + sib + disp_len + imm_len. N is computed combinationally from the inputs at accept.
- Illegal request: rep=11, disp_len/imm_len not in {0,1,2,4}, sib without modrm, or N>12.
  - The request is still consumed.
  - err pulses the cycle after accept.
  - No bytes are emitted; instr_valid does not pulse; raw_instr and instr_len are unchanged.
- FSM states: IDLE, EMIT.
  - IDLE: in_ready=1. A legal accept latches the 12-byte buffer (zero-filled beyond N), sets len=N, sets idx=0 and enters EMIT.
  - EMIT: out_byte_valid=1, out_byte=buf[idx], out_byte_last=(idx==len-1).
    - A handshake that is not the last byte increments idx.
    - The last-byte handshake returns to IDLE, copies buf to raw_instr and len to instr_len, and pulses instr_valid in the next cycle.
- While out_byte_valid=1 and ready=0, out_byte and out_byte_last hold stable.
- in_ready=0 throughout EMIT. Requests are never queued.
- idx is 4 bits and never exceeds len-1, so it cannot wrap.

## Timing
- Reset values: state IDLE, idx 0, buffer 0, raw_instr 0, instr_len 0. instr_valid, err, out_byte_valid, out_byte_last and out_byte are all 0.
- in_ready is 0 while rst is high and 1 from the first cycle after deassertion.
- Reset asserted mid-emission aborts immediately. Outputs take reset values, there is no instr_valid pulse, and raw_instr is cleared.
- Accept at edge T: first byte valid in cycle T+1.
- With ready held high, byte k is transferred in cycle T+1+k.
- The final handshake is in cycle T+N. instr_valid pulses in cycle T+N+1, and in_ready=1 in the same cycle.
- Back-to-back throughput: one N-byte instruction per N+1 cycles.
- err pulses in cycle T+1. in_ready stays 1, so another request may be accepted at T+1.
- All outputs are registered except in_ready, which is decoded from state and rst.

## Test plan
- NOP: opcode 0x90, all else off -> single byte 0x90 with last=1; instr_valid; instr_len=1; raw_instr=0x90 followed by 88 zero bits.
- IMUL r16: opsize16, 2byte, opcode 0xAF, modrm 0xC3 -> bytes 66 0F AF C3; instr_len=4; raw_instr[95:64]=0x660FAFC3.
- MOV m32,imm32: opcode C7, modrm 84, sib 8B, disp_len 4 disp 0x12345678, imm_len 4 imm 0xDEADBEEF -> C7 84 8B 78 56 34 12 EF BE AD DE; instr_len=11; last only on DE.
- Backpressure: in the previous case, drop out_byte_ready for 3 cycles after byte 3 -> out_byte holds 0x78 throughout; total 11 handshakes; instr_valid exactly once.
- Illegal requests -> err pulse only, no out_byte_valid, instr_len unchanged; next legal request encodes correctly.
  - All prefixes, 2byte, modrm, sib, disp 4, imm 4 (N=15).
  - disp_len=3.
  - sib without modrm.
- Reset mid-stream: assert rst after byte 2 of the MOV case -> outputs zero asynchronously; in_ready high after release; NOP then encodes with instr_len=1.
